tt_loopback_bist: RTL

- Parametrised built-in self-test engine for the Tiny Tapeout user project.
- Launches one pattern per cycle onto an output bus and compares the looped-back input bus, LAT cycles later, against a delayed copy of what it sent.
- Counts mismatches and records the first failing vector index.
- Supports four pattern modes and a programmable run length; generalises the fixed 8-bit IO harness used for chip bring-up.

---
 rtl/tt_loopback_bist.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/tt_loopback_bist.sv
// Loopback BIST: launches one pattern per cycle, compares the looped-back bus LAT cycles later.
// Latency: done at start+len+LAT+1; no backpressure, the pattern stream never stalls.
module tt_loopback_bist #(
  parameter int              WIDTH = 8,
  parameter int              LAT   = 2,
  parameter int              CNT_W = 16,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(8'hA5),
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] len,
  output logic [WIDTH-1:0] pat_out,
  output logic             pat_valid,
  input  logic [WIDTH-1:0] pat_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_valid
);

  localparam int XW = (WIDTH > CNT_W) ? WIDTH : CNT_W;

  function automatic logic [WIDTH-1:0] chk_init();
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i += 2) v[i] = 1'b1;
    return v;
  endfunction

  localparam logic [WIDTH-1:0] CHK = chk_init();

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       mode_r;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] walk;
  logic [4:0]       drain_cnt;

  logic             accept, last_vec, drain_end, launch;
  logic [1:0]       gen_mode;
  logic [CNT_W-1:0] gen_idx;
  logic [WIDTH-1:0] gen_lfsr, gen_walk, gen_vec;
  logic [XW-1:0]    gen_idx_x;

  logic             pipe_vld [LAT];
  logic [WIDTH-1:0] pipe_dat [LAT];
  logic [CNT_W-1:0] pipe_idx [LAT];
  logic             miss;

  assign accept    = (state == S_IDLE) && start;
  assign last_vec  = (state == S_RUN) && (idx == len_r - CNT_W'(1));
  assign drain_end = (state == S_DRAIN) && (drain_cnt == 5'(LAT - 1));
  assign launch    = (accept && (len != '0)) || ((state == S_RUN) && !last_vec);
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (last_vec) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_end) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Generator registers hold the vector currently on pat_out; on accept they restart at vector 0.
  always_comb begin
    gen_mode  = accept ? mode : mode_r;
    gen_idx   = accept ? '0 : idx + CNT_W'(1);
    gen_lfsr  = accept ? SEED : (lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1));
    gen_walk  = accept ? WIDTH'(1) : {walk[WIDTH-2:0], walk[WIDTH-1]};
    gen_idx_x = XW'(gen_idx);
    gen_vec   = '0;
    case (gen_mode)
      2'd0: gen_vec = gen_lfsr;
      2'd1: gen_vec = gen_walk;
      2'd2: gen_vec = gen_idx_x[WIDTH-1:0];
      2'd3: gen_vec = gen_idx[0] ? ~CHK : CHK;
      default: gen_vec = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r    <= '0;
      len_r     <= '0;
      idx       <= '0;
      lfsr      <= SEED;
      walk      <= WIDTH'(1);
      pat_out   <= '0;
      pat_valid <= 1'b0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        mode_r <= mode;
        len_r  <= len;
      end
      if (launch) begin
        pat_out   <= gen_vec;
        pat_valid <= 1'b1;
        idx       <= gen_idx;
        lfsr      <= gen_lfsr;
        walk      <= gen_walk;
      end else begin
        pat_out   <= '0;
        pat_valid <= 1'b0;
      end
      if (state == S_RUN)        drain_cnt <= '0;
      else if (state == S_DRAIN) drain_cnt <= drain_cnt + 5'd1;
    end
  end

  // Delay line aligns each launched vector with its loopback sample LAT cycles later.
  assign miss = pipe_vld[LAT-1] && (pipe_dat[LAT-1] != pat_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_dat[i] <= '0;
        pipe_idx[i] <= '0;
      end
      err_cnt         <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      pipe_vld[0] <= pat_valid;
      pipe_dat[0] <= pat_out;
      pipe_idx[0] <= idx;
      for (int i = 1; i < LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
      if (accept) begin
        err_cnt         <= '0;
        first_err_idx   <= '0;
        first_err_valid <= 1'b0;
      end else if (miss) begin
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        if (!first_err_valid) begin
          first_err_idx   <= pipe_idx[LAT-1];
          first_err_valid <= 1'b1;
        end
      end
    end
  end

endmodule
